// File: rtl/pc_fetch_ctrl.sv
// IF-stage program counter with ID-stage transfer decode, delayed-branch redirect
// and a sticky misaligned-target trap. Optional branch-likely support: PCF_BLIKELY_EN.
module pc_fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic        cmp_taken,
    input  logic [31:0] rs_data,
    output logic [31:0] f_pc,
    output logic [31:0] d_link,
    output logic        redirect,
    output logic        addr_err,
    output logic [31:0] err_pc
`ifdef PCF_BLIKELY_EN
    ,
    output logic        f_nullify
`endif
);

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic {S_RUN = 1'b0, S_ERR = 1'b1} state_t;

    state_t state_q, state_d;

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic        addr_err_q, addr_err_d;
`ifdef PCF_BLIKELY_EN
    logic        nullify_q, nullify_d;
    logic        is_likely;
`endif

    logic [5:0]        op;
    logic [4:0]        rt;
    logic [5:0]        funct;
    logic              is_cbr, is_jmp, is_jreg;
    logic [31:0]       pc_plus4;
    logic signed [31:0] br_off;
    logic [31:0]       target;
    logic              taken, misaligned, run_go, trap;

    assign op     = d_instr[31:26];
    assign rt     = d_instr[20:16];
    assign funct  = d_instr[5:0];
    assign d_link = d_pc + 32'd8;

    always_comb begin
        is_cbr  = 1'b0;
        is_jmp  = 1'b0;
        is_jreg = 1'b0;
`ifdef PCF_BLIKELY_EN
        is_likely = 1'b0;
`endif
        case (op)
            6'b000100, 6'b000101, 6'b000110, 6'b000111: is_cbr = 1'b1;
            6'b000001: is_cbr = (rt == 5'b00000) || (rt == 5'b00001) || (rt == 5'b10001);
            6'b000010, 6'b000011: is_jmp = 1'b1;
            6'b000000: is_jreg = (funct == 6'b001000) || (funct == 6'b001001);
`ifdef PCF_BLIKELY_EN
            6'b010100, 6'b010101, 6'b010110, 6'b010111: begin
                is_cbr    = 1'b1;
                is_likely = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Target selection; all arithmetic wraps modulo 2^32.
    always_comb begin
        pc_plus4 = d_pc + 32'd4;
        br_off   = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
        if (is_jreg)
            target = rs_data;
        else if (is_jmp)
            target = {pc_plus4[31:28], d_instr[25:0], 2'b00};
        else
            target = pc_plus4 + $unsigned(br_off);
    end

    assign taken      = is_jmp | is_jreg | (is_cbr & cmp_taken);
    assign misaligned = |target[1:0];
    assign run_go     = (state_q == S_RUN) && !stall;
    assign trap       = run_go && taken && misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (trap)
            state_d = S_ERR;
    end

    always_comb begin
        redirect   = run_go && taken && !misaligned;
        f_pc_d     = f_pc_q;
        err_pc_d   = err_pc_q;
        addr_err_d = addr_err_q;
`ifdef PCF_BLIKELY_EN
        nullify_d  = (state_q == S_RUN) ? nullify_q : 1'b0;
`endif
        if (run_go) begin
            if (trap) begin
                err_pc_d   = target;
                addr_err_d = 1'b1;
            end else if (taken) begin
                f_pc_d = target;
            end else begin
                f_pc_d = f_pc_q + 32'd4;
            end
`ifdef PCF_BLIKELY_EN
            // An un-taken likely branch squashes its delay slot for one fetch.
            nullify_d = is_likely && !cmp_taken;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q     <= RESET_PC;
            err_pc_q   <= 32'd0;
            addr_err_q <= 1'b0;
`ifdef PCF_BLIKELY_EN
            nullify_q  <= 1'b0;
`endif
        end else begin
            f_pc_q     <= f_pc_d;
            err_pc_q   <= err_pc_d;
            addr_err_q <= addr_err_d;
`ifdef PCF_BLIKELY_EN
            nullify_q  <= nullify_d;
`endif
        end
    end

    assign f_pc     = f_pc_q;
    assign err_pc   = err_pc_q;
    assign addr_err = addr_err_q;
`ifdef PCF_BLIKELY_EN
    assign f_nullify = nullify_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: constant vector table, hand-written corner sequences and
// randomized traffic against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        cmp_taken;
    logic [31:0] rs_data;
    logic [31:0] f_pc;
    logic [31:0] d_link;
    logic        redirect;
    logic        addr_err;
    logic [31:0] err_pc;
`ifdef PCF_BLIKELY_EN
    logic        f_nullify;
`endif

    pc_fetch_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .d_instr   (d_instr),
        .d_pc      (d_pc),
        .cmp_taken (cmp_taken),
        .rs_data   (rs_data),
        .f_pc      (f_pc),
        .d_link    (d_link),
        .redirect  (redirect),
        .addr_err  (addr_err),
        .err_pc    (err_pc)
`ifdef PCF_BLIKELY_EN
        ,
        .f_nullify (f_nullify)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: fetch PC, sticky error flag, captured target, nullify flag.
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_epc;
    logic        m_nul;

    typedef struct {
        logic        st;
        logic [31:0] ins;
        logic [31:0] dpc;
        logic        cmp;
        logic [31:0] rs;
        logic        exp_red;
        logic [31:0] exp_link;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_xfer(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [31:0] rs, input logic cmp,
                                     output logic tk, output logic [31:0] tgt,
                                     output logic lk);
        int op;
        int rt;
        int fn;
        int imm;
        logic [31:0] seq;
        op  = int'({26'd0, ins[31:26]});
        rt  = int'({27'd0, ins[20:16]});
        fn  = int'({26'd0, ins[5:0]});
        imm = int'($signed(ins[15:0]));
        seq = pc + 32'd4;
        tk  = 1'b0;
        tgt = 32'd0;
        lk  = 1'b0;
        if ((op >= 4 && op <= 7) || (op == 1 && (rt == 0 || rt == 1 || rt == 17))) begin
            tk  = cmp;
            tgt = seq + 32'(imm * 4);
        end else if (op == 2 || op == 3) begin
            tk  = 1'b1;
            tgt = {seq[31:28], ins[25:0], 2'b00};
        end else if (op == 0 && (fn == 8 || fn == 9)) begin
            tk  = 1'b1;
            tgt = rs;
        end
`ifdef PCF_BLIKELY_EN
        else if (op >= 20 && op <= 23) begin
            tk  = cmp;
            tgt = seq + 32'(imm * 4);
            lk  = 1'b1;
        end
`endif
    endfunction

    // Called at posedge+1; leaves at the following posedge+1.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("async_rst_f_pc", f_pc, 32'h0000_3000);
        chk("async_rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("async_rst_err_pc", err_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc  = 32'h0000_3000;
        m_err = 1'b0;
        m_epc = 32'd0;
        m_nul = 1'b0;
    endtask

    task automatic step(input logic st, input logic [31:0] ins, input logic [31:0] dpc,
                        input logic cmp, input logic [31:0] rs);
        logic        tk;
        logic        lk;
        logic [31:0] tgt;
        logic        acc;
        stall     = st;
        d_instr   = ins;
        d_pc      = dpc;
        cmp_taken = cmp;
        rs_data   = rs;
        ref_xfer(ins, dpc, rs, cmp, tk, tgt, lk);
        acc = !m_err && !st;
        #4;
        chk("redirect", {31'd0, redirect}, {31'd0, acc && tk && (tgt[1:0] == 2'b00)});
        chk("d_link", d_link, dpc + 32'd8);
        @(posedge clk);
        #1;
        if (m_err) begin
            m_nul = 1'b0;
        end else if (!st) begin
            m_nul = lk && !cmp;
            if (tk && tgt[1:0] != 2'b00) begin
                m_err = 1'b1;
                m_epc = tgt;
            end else begin
                m_pc = tk ? tgt : m_pc + 32'd4;
            end
        end
        chk("f_pc", f_pc, m_pc);
        chk("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        chk("err_pc", err_pc, m_epc);
`ifdef PCF_BLIKELY_EN
        chk("f_nullify", {31'd0, f_nullify}, {31'd0, m_nul});
`endif
    endtask

    task automatic add_vec(input logic st, input logic [31:0] ins, input logic [31:0] dpc,
                           input logic cmp, input logic [31:0] rs, input logic er,
                           input logic [31:0] el, input logic [31:0] en);
        vecs[nvec] = '{st, ins, dpc, cmp, rs, er, el, en};
        nvec++;
    endtask

    logic [31:0] r_ins;
    logic [31:0] r_pc;
    logic [31:0] r_rs;

    initial begin
        reset = 1'b1; stall = 1'b0; d_instr = 32'd0; d_pc = 32'd0;
        cmp_taken = 1'b0; rs_data = 32'd0;
        nvec = 0;
        //       st  instr         d_pc          cmp rs            red link          next f_pc
        add_vec(0, 32'h0000_0000, 32'h0000_3000, 0, 32'h0,         0, 32'h0000_3008, 32'h0000_3004);
        add_vec(0, 32'h1000_0003, 32'h0000_3004, 1, 32'h0,         1, 32'h0000_300C, 32'h0000_3014);
        add_vec(0, 32'h1000_0003, 32'h0000_3004, 0, 32'h0,         0, 32'h0000_300C, 32'h0000_3004);
        add_vec(0, 32'h0C00_0C10, 32'h0000_3008, 0, 32'h0,         1, 32'h0000_3010, 32'h0000_3040);
        add_vec(0, 32'h0800_0C10, 32'hF000_0000, 0, 32'h0,         1, 32'hF000_0008, 32'hF000_3040);
        add_vec(0, 32'h03E0_0008, 32'h0000_3000, 0, 32'h1234_5678, 1, 32'h0000_3008, 32'h1234_5678);
        add_vec(0, 32'h03E0_F809, 32'h0000_3000, 0, 32'h0000_4000, 1, 32'h0000_3008, 32'h0000_4000);
        add_vec(0, 32'h0000_0021, 32'h0000_3000, 1, 32'h0000_4000, 0, 32'h0000_3008, 32'h0000_3004);
        add_vec(0, 32'h0411_FFFF, 32'h0000_3010, 1, 32'h0,         1, 32'h0000_3018, 32'h0000_3010);
        add_vec(0, 32'h0402_FFFF, 32'h0000_3010, 1, 32'h0,         0, 32'h0000_3018, 32'h0000_3004);
        add_vec(0, 32'h1400_8000, 32'h0000_3000, 1, 32'h0,         1, 32'h0000_3008, 32'hFFFE_3004);
        add_vec(1, 32'h03E0_0008, 32'h0000_3000, 0, 32'h0000_3040, 0, 32'h0000_3008, 32'h0000_3000);
        add_vec(0, 32'h1800_0002, 32'h0000_3000, 1, 32'h0,         1, 32'h0000_3008, 32'h0000_300C);
        add_vec(0, 32'h1C00_0001, 32'h0000_3000, 0, 32'h0,         0, 32'h0000_3008, 32'h0000_3004);
`ifdef PCF_BLIKELY_EN
        add_vec(0, 32'h5000_0003, 32'h0000_3000, 1, 32'h0,         1, 32'h0000_3008, 32'h0000_3010);
`else
        add_vec(0, 32'h5000_0003, 32'h0000_3000, 1, 32'h0,         0, 32'h0000_3008, 32'h0000_3004);
`endif

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < nvec; i++) begin
            do_reset();
            stall     = vecs[i].st;
            d_instr   = vecs[i].ins;
            d_pc      = vecs[i].dpc;
            cmp_taken = vecs[i].cmp;
            rs_data   = vecs[i].rs;
            #4;
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_red});
            chk($sformatf("vec%0d_d_link", i), d_link, vecs[i].exp_link);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_f_pc", i), f_pc, vecs[i].exp_next);
        end

        // Sequential fetch after reset release.
        do_reset();
        chk("seq_f_pc0", f_pc, 32'h0000_3000);
        for (int i = 1; i <= 3; i++) begin
            step(0, 32'd0, 32'h0000_2FFC, 0, 32'd0);
            chk($sformatf("seq_f_pc%0d", i), f_pc, 32'h0000_3000 + 32'(4 * i));
        end

        // jr held by a two-cycle stall, then accepted.
        do_reset();
        step(1, 32'h03E0_0008, 32'h0000_3000, 1, 32'h0000_3040);
        step(1, 32'h03E0_0008, 32'h0000_3000, 1, 32'h0000_3040);
        chk("stall_hold_f_pc", f_pc, 32'h0000_3000);
        step(0, 32'h03E0_0008, 32'h0000_3000, 0, 32'h0000_3040);
        chk("stall_release_f_pc", f_pc, 32'h0000_3040);

        // PC wrap at the top of the address space.
        step(0, 32'h03E0_0008, 32'h0000_3040, 0, 32'hFFFF_FFFC);
        step(0, 32'd0, 32'h0000_3044, 0, 32'd0);
        chk("wrap_f_pc", f_pc, 32'h0000_0000);

        // Misaligned jr traps; fetch freezes until reset, then restarts at 0x3000.
        do_reset();
        step(0, 32'h03E0_0008, 32'h0000_3000, 0, 32'h0000_3002);
        chk("trap_addr_err", {31'd0, addr_err}, 32'd1);
        chk("trap_err_pc", err_pc, 32'h0000_3002);
        for (int i = 0; i < 10; i++)
            step(i[0], (i < 5) ? 32'h03E0_0008 : 32'd0, 32'h0000_3004, 1, 32'h0000_4000);
        chk("frozen_f_pc", f_pc, 32'h0000_3000);
        do_reset();
        chk("post_err_addr_err", {31'd0, addr_err}, 32'd0);
        step(0, 32'd0, 32'h0000_3000, 0, 32'd0);
        chk("post_err_f_pc", f_pc, 32'h0000_3004);

        // Reset asserted in the middle of a stall.
        step(0, 32'h0800_0C10, 32'h0000_3000, 0, 32'd0);
        step(1, 32'd0, 32'h0000_3040, 0, 32'd0);
        do_reset();
        step(0, 32'd0, 32'h0000_3000, 0, 32'd0);

`ifdef PCF_BLIKELY_EN
        // Un-taken beql squashes the delay slot for exactly one cycle.
        do_reset();
        step(0, 32'd0, 32'h0000_2FFC, 0, 32'd0);
        step(0, 32'h5000_0003, 32'h0000_3000, 0, 32'd0);
        chk("beql_nullify", {31'd0, f_nullify}, 32'd1);
        chk("beql_f_pc", f_pc, 32'h0000_3008);
        step(0, 32'd0, 32'h0000_3004, 0, 32'd0);
        chk("beql_nullify_clear", {31'd0, f_nullify}, 32'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 40 == 39) do_reset();
            r_pc = ($urandom_range(0, 29) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_rs = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_ins = $urandom;
            case ($urandom_range(0, 7))
                0: r_ins[31:26] = 6'h23;
                1: r_ins[31:26] = 6'(4 + $urandom_range(0, 3));
                2: begin
                    r_ins[31:26] = 6'b000001;
                    case ($urandom_range(0, 3))
                        0: r_ins[20:16] = 5'b00000;
                        1: r_ins[20:16] = 5'b00001;
                        2: r_ins[20:16] = 5'b10001;
                        default: r_ins[20:16] = 5'b00010;
                    endcase
                end
                3: r_ins[31:26] = 6'b000010;
                4: r_ins[31:26] = 6'b000011;
                5: begin r_ins[31:26] = 6'b000000; r_ins[5:0] = 6'b001000; end
                6: begin r_ins[31:26] = 6'b000000; r_ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'b100001 : 6'b001001; end
                default: r_ins[31:26] = 6'(20 + $urandom_range(0, 3));
            endcase
            step($urandom_range(0, 3) == 0, r_ins, r_pc, 1'($urandom_range(0, 1)), r_rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-side program-counter unit for the five-stage MIPS pipeline; it is the consumer of the ID-stage branch-comparison result. It holds the IF-stage PC, decodes the control-transfer instruction sitting in ID, combines it with the comparator verdict and forwarded `rs` data, and redirects fetch under the delayed-branch model. It also traps misaligned jump targets into a sticky error state that freezes fetch.

## Interface
- No parameters; reset vector fixed at 32'h0000_3000.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  hazard-unit stall; PC and FSM hold.
- `d_instr`  in  32  instruction currently in ID.
- `d_pc`  in  32  PC of `d_instr`.
- `cmp_taken`  in  1  ID-stage branch condition (beq/bne/blez/bgtz/bltz/bgez/bgezal).
- `rs_data`  in  32  forwarded GPR[rs] for jr/jalr.
- `f_pc`  out  32  current fetch PC (registered).
- `d_link`  out  32  `d_pc + 8`, link value for jal/jalr/bgezal.
- `redirect`  out  1  combinational; high when a taken transfer is accepted this cycle.
- `addr_err`  out  1  sticky misaligned-target flag (registered).
- `err_pc`  out  32  offending target captured on error (registered).
- `f_nullify`  out  1  present only with `PCF_BLIKELY_EN`; see Configuration.

## Operation
- Decode of `d_instr`: op 000100/000101/000110/000111 → conditional branch; op 000001 with rt 00000/00001/10001 → conditional branch; op 000010 (j), 000011 (jal) → jump; op 000000 with funct 001000 (jr) / 001001 (jalr) → register jump. Any other encoding (including other SPECIAL functs) is not a transfer.
- Targets, all modulo 2^32: branch = `d_pc + 4 + (sext(imm16) << 2)`; j/jal = `{(d_pc+4)[31:28], instr_index, 2'b00}`; jr/jalr = `rs_data`.
- `taken` = jump | register jump | (conditional branch & `cmp_taken`).
- `next_pc` = taken ? target : `f_pc + 4` (wrap 32'hFFFF_FFFC → 32'h0000_0000).
- Delay slot: the instruction at `d_pc+4` is already in IF when the transfer is in ID; it always executes. No flush is generated.
- FSM states: RUN, ERR.
  - RUN, `stall`=0: `f_pc` ← `next_pc`. If taken and target[1:0] ≠ 0: `f_pc` holds, `err_pc` ← target, `addr_err` ← 1, go ERR.
  - RUN, `stall`=1: everything holds; `redirect` forced 0; `cmp_taken`/`rs_data` ignored.
  - ERR: `f_pc`, `err_pc` frozen, `redirect`=0; leaves only via `reset`.
- `redirect` = state RUN & !`stall` & taken & aligned target.

## Timing
- Reset values: `f_pc`=32'h0000_3000, `addr_err`=0, `err_pc`=0, `f_nullify`=0, state RUN.
- Redirect latency: one edge; target visible on `f_pc` the cycle after the accepting cycle.
- `d_link` is purely combinational from `d_pc`; zero latency.
- Stall and taken in the same cycle: stall wins; decision re-evaluated when stall drops.
- Reset asserted mid-stall or in ERR: outputs return to reset values asynchronously; first fetch after deassertion is 0x3000.

## Configuration
- `PCF_BLIKELY_EN` defined: additionally decode beql/bnel/blezl/bgtzl (op 010100/010101/010110/010111) as conditional branches; when one is accepted un-taken (RUN, !stall, `cmp_taken`=0), `f_nullify` registers 1 for exactly one cycle so the delay-slot instruction is squashed at IF/ID; `f_nullify` holds during stall.
- Not defined: those opcodes are non-transfers, `f_nullify` port is absent.

## Test plan
- Reset release, no transfers, no stall, 3 cycles → `f_pc` = 0x3000, 0x3004, 0x3008, 0x300C.
- beq at `d_pc`=0x3004, imm=0x0003, `cmp_taken`=1 → `redirect`=1, next `f_pc`=0x3014; same with `cmp_taken`=0 → `f_pc`+4.
- jal at `d_pc`=0x3008, index=0x0000C10 → `d_link`=0x3010, next `f_pc`=0x3040.
- jr with `rs_data`=0x3040 while `stall`=1 for 2 cycles → `f_pc` and `redirect`=0 held; after stall drops → `f_pc`=0x3040.
- jr with `rs_data`=0x3002 → `addr_err`=1, `err_pc`=0x3002, `f_pc` frozen 10 cycles; `reset` pulse → `f_pc`=0x3000, `addr_err`=0.
- (`PCF_BLIKELY_EN`) beql un-taken at `d_pc`=0x3000 → `f_nullify`=1 for one cycle, `f_pc`=0x3008 next.
